// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks a wrap-around range of register-file indices through a
// spare read port and streams each captured value out over a valid/ready interface.
module reg_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] first_reg,
   input  logic [ADDR_W-1:0] last_reg,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] last_q;
   logic [ADDR_W-1:0] ptr_next;

   // Index space is a power of two, so the wrap is explicit only for clarity.
   assign ptr_next = (ptr == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

   // NOTE: every output of a combinational block gets a default first, otherwise
   // a path that skips the assignment infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = LOAD;
         LOAD: state_d = abort ? IDLE : SEND;
         SEND: begin
            if (abort)          state_d = IDLE;
            else if (out_ready) state_d = out_last ? DONE : LOAD;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples
   // the pre-edge values, regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr       <= '0;
         last_q    <= '0;
         rf_addr   <= '0;
         out_data  <= '0;
         out_index <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  ptr     <= first_reg;
                  last_q  <= last_reg;
                  rf_addr <= first_reg;
               end
            end
            LOAD: begin
               if (abort) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end else begin
                  out_data  <= rf_data;
                  out_index <= ptr;
                  out_last  <= (ptr == last_q);
                  out_valid <= 1'b1;
               end
            end
            SEND: begin
               if (abort || out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  // Abort wins over a simultaneous handshake: no further fetch.
                  if (!abort && !out_last) begin
                     ptr     <= ptr_next;
                     rf_addr <= ptr_next;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
